// File: rtl/ps2_kb_decoder_pkg.sv
// Shared types and constants for the PS/2 keyboard to SNES key-state decoder.
// Holds the FSM state encodings, the SNES bit positions, the scan codes and the scan-code-to-key maps.
package ps2_kb_decoder_pkg;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    typedef enum logic [1:0] {
        DEC_BASE,
        DEC_EXT,
        DEC_BRK,
        DEC_EXT_BRK
    } dec_state_t;

    localparam int KEY_B      = 0;
    localparam int KEY_Y      = 1;
    localparam int KEY_SELECT = 2;
    localparam int KEY_START  = 3;
    localparam int KEY_UP     = 4;
    localparam int KEY_DOWN   = 5;
    localparam int KEY_LEFT   = 6;
    localparam int KEY_RIGHT  = 7;

    localparam logic [7:0] SC_B        = 8'h1A;
    localparam logic [7:0] SC_Y        = 8'h22;
    localparam logic [7:0] SC_SELECT   = 8'h59;
    localparam logic [7:0] SC_START    = 8'h5A;
    localparam logic [7:0] SC_UP       = 8'h75;
    localparam logic [7:0] SC_DOWN     = 8'h72;
    localparam logic [7:0] SC_LEFT     = 8'h6B;
    localparam logic [7:0] SC_RIGHT    = 8'h74;
    localparam logic [7:0] SC_EXT      = 8'hE0;
    localparam logic [7:0] SC_BREAK    = 8'hF0;
    localparam logic [7:0] SC_BAT_OK   = 8'hAA;
    localparam logic [7:0] SC_ACK      = 8'hFA;
    localparam logic [7:0] SC_ECHO     = 8'hEE;
    localparam logic [7:0] SC_BAT_FAIL = 8'hFC;
    localparam logic [7:0] SC_ERR0     = 8'h00;
    localparam logic [7:0] SC_OVF      = 8'hFF;

    // One-hot key mask for an unprefixed code; zero when the code is not mapped.
    function automatic logic [7:0] plain_mask(input logic [7:0] code);
        logic [7:0] m;
        m = '0;
        case (code)
            SC_B:      m[KEY_B]      = 1'b1;
            SC_Y:      m[KEY_Y]      = 1'b1;
            SC_SELECT: m[KEY_SELECT] = 1'b1;
            SC_START:  m[KEY_START]  = 1'b1;
            default:   m = '0;
        endcase
        return m;
    endfunction

    // One-hot key mask for an E0-prefixed code; zero when the code is not mapped.
    function automatic logic [7:0] ext_mask(input logic [7:0] code);
        logic [7:0] m;
        m = '0;
        case (code)
            SC_UP:    m[KEY_UP]    = 1'b1;
            SC_DOWN:  m[KEY_DOWN]  = 1'b1;
            SC_LEFT:  m[KEY_LEFT]  = 1'b1;
            SC_RIGHT: m[KEY_RIGHT] = 1'b1;
            default:  m = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ps2_kb_decoder_rx_frame.sv
// PS/2 frame receiver: input synchronizers, ps2_clk falling-edge detect, 11-bit frame FSM, timeout.
// Emits one-cycle byte_valid / frame_err pulses; byte_data holds the last good byte.
module ps2_rx_frame
    import ps2_kb_decoder_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 2000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   clk_prev;
    logic                   clk_s;
    logic                   data_s;
    logic                   fall;

    rx_state_t              state;
    logic [2:0]             bit_cnt;
    logic [7:0]             shift;
    logic                   parity;
    logic [CNT_W-1:0]       tmo_cnt;

    assign clk_s  = clk_sync[SYNC_STAGES-1];
    assign data_s = data_sync[SYNC_STAGES-1];
    assign fall   = clk_prev & ~clk_s;

    // Synchronizers reset to 1 so an idle bus does not look like a falling edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync  <= '1;
            data_sync <= '1;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
            clk_prev  <= clk_s;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= RX_IDLE;
            bit_cnt    <= '0;
            shift      <= '0;
            parity     <= 1'b0;
            tmo_cnt    <= '0;
            byte_valid <= 1'b0;
            byte_data  <= '0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (fall) begin
                tmo_cnt <= '0;
                case (state)
                    RX_IDLE: begin
                        if (!data_s) begin
                            state   <= RX_DATA;
                            bit_cnt <= '0;
                        end
                    end
                    RX_DATA: begin
                        shift   <= {data_s, shift[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= RX_PARITY;
                        end
                    end
                    RX_PARITY: begin
                        parity <= data_s;
                        state  <= RX_STOP;
                    end
                    RX_STOP: begin
                        // Odd parity: data plus parity bit must hold an odd number of ones.
                        if (data_s && (^{shift, parity})) begin
                            byte_valid <= 1'b1;
                            byte_data  <= shift;
                        end else begin
                            frame_err <= 1'b1;
                        end
                        state <= RX_IDLE;
                    end
                    default: state <= RX_IDLE;
                endcase
            end else if (state != RX_IDLE) begin
                if (tmo_cnt == CNT_LAST) begin
                    frame_err <= 1'b1;
                    state     <= RX_IDLE;
                    tmo_cnt   <= '0;
                end else begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                end
            end else begin
                tmo_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/ps2_kb_decoder.sv
// PS/2 keyboard decoder: turns make/break scan codes into an 8-bit SNES held-button vector.
// Framing lives in ps2_rx_frame; this level runs the prefix FSM and owns key_state.
module ps2_kb_decoder
    import ps2_kb_decoder_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 2000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] key_state,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    dec_state_t dec_state;

    ps2_rx_frame #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .SYNC_STAGES   (SYNC_STAGES)
    ) u_rx (
        .clk       (clk),
        .reset_n   (reset_n),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .byte_valid(byte_valid),
        .byte_data (byte_data),
        .frame_err (frame_err)
    );

    // Byte stage -> key stage: key_state lands one clk after byte_valid.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dec_state <= DEC_BASE;
            key_state <= '0;
        end else if (frame_err) begin
            dec_state <= DEC_BASE;
        end else if (byte_valid) begin
            case (byte_data)
                SC_BAT_OK, SC_ACK, SC_ECHO: begin
                    dec_state <= dec_state;
                end
                SC_BAT_FAIL, SC_ERR0, SC_OVF: begin
                    key_state <= '0;
                    dec_state <= DEC_BASE;
                end
                default: begin
                    case (dec_state)
                        DEC_BASE: begin
                            if (byte_data == SC_EXT) begin
                                dec_state <= DEC_EXT;
                            end else if (byte_data == SC_BREAK) begin
                                dec_state <= DEC_BRK;
                            end else begin
                                key_state <= key_state | plain_mask(byte_data);
                                dec_state <= DEC_BASE;
                            end
                        end
                        DEC_EXT: begin
                            if (byte_data == SC_BREAK) begin
                                dec_state <= DEC_EXT_BRK;
                            end else begin
                                key_state <= key_state | ext_mask(byte_data);
                                dec_state <= DEC_BASE;
                            end
                        end
                        DEC_BRK: begin
                            key_state <= key_state & ~plain_mask(byte_data);
                            dec_state <= DEC_BASE;
                        end
                        DEC_EXT_BRK: begin
                            key_state <= key_state & ~ext_mask(byte_data);
                            dec_state <= DEC_BASE;
                        end
                        default: dec_state <= DEC_BASE;
                    endcase
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_kb_decoder.sv
// Directed bench for ps2_kb_decoder: table of scan-code frames plus hand-written timing,
// timeout and mid-frame reset sequences.
module tb_ps2_kb_decoder;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] key_state;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       frame_err;

    int checks = 0;
    int errors = 0;
    int bv_tot = 0;
    int fe_tot = 0;

    typedef struct {
        logic [7:0] code;
        logic       bad_par;
        logic [7:0] exp_key;
        int         exp_bv;
        int         exp_fe;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[$];

    ps2_kb_decoder #(
        .TIMEOUT_CYCLES(2000),
        .SYNC_STAGES   (2)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .key_state (key_state),
        .byte_valid(byte_valid),
        .byte_data (byte_data),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (byte_valid) bv_tot <= bv_tot + 1;
        if (frame_err)  fe_tot <= fe_tot + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic d);
        @(negedge clk);
        ps2_data = d;
        repeat (5) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (5) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par);
        logic p;
        p = (~^b) ^ bad_par;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(p);
        send_bit(1'b1);
        repeat (5) @(negedge clk);
    endtask

    initial begin
        int bv0;
        int fe0;
        logic [7:0] b;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_key_state", key_state, 8'h00);
        check("reset_byte_data", byte_data, 8'h00);
        check("reset_byte_valid", byte_valid, 1'b0);
        check("reset_frame_err", frame_err, 1'b0);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);

        // Frame 1A with exact latency check on the stop-bit edge
        bv0 = bv_tot;
        b = 8'h1A;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(~^b);
        @(negedge clk);
        ps2_data = 1'b1;
        repeat (5) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (2) @(negedge clk);
        check("stop_bv_before", byte_valid, 1'b0);
        @(negedge clk);
        check("stop_bv_pulse", byte_valid, 1'b1);
        check("stop_data", byte_data, 8'h1A);
        check("stop_key_not_yet", key_state, 8'h00);
        @(negedge clk);
        check("stop_bv_after", byte_valid, 1'b0);
        check("stop_key_updated", key_state, 8'h01);
        repeat (2) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (10) @(negedge clk);
        check("stop_bv_count", bv_tot - bv0, 1);

        // Table of frames: code, bad parity, expected key_state, byte_valid count, frame_err count, byte_data
        vecs.push_back('{8'hF0, 1'b0, 8'h01, 1, 0, 8'hF0});
        vecs.push_back('{8'h1A, 1'b0, 8'h00, 1, 0, 8'h1A});
        vecs.push_back('{8'hE0, 1'b0, 8'h00, 1, 0, 8'hE0});
        vecs.push_back('{8'h75, 1'b0, 8'h10, 1, 0, 8'h75});
        vecs.push_back('{8'hE0, 1'b0, 8'h10, 1, 0, 8'hE0});
        vecs.push_back('{8'h75, 1'b0, 8'h10, 1, 0, 8'h75});
        vecs.push_back('{8'hE0, 1'b0, 8'h10, 1, 0, 8'hE0});
        vecs.push_back('{8'hF0, 1'b0, 8'h10, 1, 0, 8'hF0});
        vecs.push_back('{8'h75, 1'b0, 8'h00, 1, 0, 8'h75});
        vecs.push_back('{8'h5A, 1'b1, 8'h00, 0, 1, 8'h75});
        vecs.push_back('{8'h5A, 1'b0, 8'h08, 1, 0, 8'h5A});
        vecs.push_back('{8'h1A, 1'b0, 8'h09, 1, 0, 8'h1A});
        vecs.push_back('{8'hAA, 1'b0, 8'h09, 1, 0, 8'hAA});
        vecs.push_back('{8'hFC, 1'b0, 8'h00, 1, 0, 8'hFC});
        vecs.push_back('{8'hE0, 1'b0, 8'h00, 1, 0, 8'hE0});
        vecs.push_back('{8'h1A, 1'b0, 8'h00, 1, 0, 8'h1A});
        vecs.push_back('{8'h75, 1'b0, 8'h00, 1, 0, 8'h75});
        vecs.push_back('{8'h22, 1'b0, 8'h02, 1, 0, 8'h22});
        vecs.push_back('{8'hE0, 1'b0, 8'h02, 1, 0, 8'hE0});
        vecs.push_back('{8'h5A, 1'b0, 8'h02, 1, 0, 8'h5A});
        vecs.push_back('{8'hE0, 1'b0, 8'h02, 1, 0, 8'hE0});
        vecs.push_back('{8'hF0, 1'b1, 8'h02, 0, 1, 8'hE0});
        vecs.push_back('{8'h1A, 1'b0, 8'h03, 1, 0, 8'h1A});
        vecs.push_back('{8'hE0, 1'b0, 8'h03, 1, 0, 8'hE0});
        vecs.push_back('{8'h6B, 1'b0, 8'h43, 1, 0, 8'h6B});
        vecs.push_back('{8'hE0, 1'b0, 8'h43, 1, 0, 8'hE0});
        vecs.push_back('{8'h72, 1'b0, 8'h63, 1, 0, 8'h72});
        vecs.push_back('{8'hE0, 1'b0, 8'h63, 1, 0, 8'hE0});
        vecs.push_back('{8'h74, 1'b0, 8'hE3, 1, 0, 8'h74});
        vecs.push_back('{8'h59, 1'b0, 8'hE7, 1, 0, 8'h59});
        vecs.push_back('{8'hFF, 1'b0, 8'h00, 1, 0, 8'hFF});

        foreach (vecs[i]) begin
            bv0 = bv_tot;
            fe0 = fe_tot;
            send_frame(vecs[i].code, vecs[i].bad_par);
            repeat (5) @(negedge clk);
            check($sformatf("vec%0d_key_%0h", i, vecs[i].code), key_state, vecs[i].exp_key);
            check($sformatf("vec%0d_bv_cnt", i), bv_tot - bv0, vecs[i].exp_bv);
            check($sformatf("vec%0d_fe_cnt", i), fe_tot - fe0, vecs[i].exp_fe);
            check($sformatf("vec%0d_data", i), byte_data, vecs[i].exp_data);
        end

        // Timeout: start bit plus 3 data bits, then ps2_clk idles high
        bv0 = bv_tot;
        fe0 = fe_tot;
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        ps2_data = 1'b1;
        repeat (1500) @(negedge clk);
        check("tmo_no_early_err", fe_tot - fe0, 0);
        repeat (700) @(negedge clk);
        check("tmo_err_once", fe_tot - fe0, 1);
        check("tmo_no_bv", bv_tot - bv0, 0);
        check("tmo_key_kept", key_state, 8'h00);
        bv0 = bv_tot;
        fe0 = fe_tot;
        send_frame(8'h22, 1'b0);
        repeat (5) @(negedge clk);
        check("tmo_next_key", key_state, 8'h02);
        check("tmo_next_bv", bv_tot - bv0, 1);
        check("tmo_next_fe", fe_tot - fe0, 0);

        // Reset asserted mid-frame, off the clock edge
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("rst_async_key", key_state, 8'h00);
        check("rst_async_data", byte_data, 8'h00);
        check("rst_async_bv", byte_valid, 1'b0);
        check("rst_async_fe", frame_err, 1'b0);
        repeat (4) @(negedge clk);
        reset_n = 1'b1;
        ps2_data = 1'b1;
        repeat (10) @(negedge clk);
        bv0 = bv_tot;
        fe0 = fe_tot;
        send_frame(8'h5A, 1'b0);
        repeat (5) @(negedge clk);
        check("rst_next_key", key_state, 8'h08);
        check("rst_next_data", byte_data, 8'h5A);
        check("rst_next_bv", bv_tot - bv0, 1);
        check("rst_next_fe", fe_tot - fe0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
